// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, fixed-latency unified memory between the
// instruction-fetch stage (I side) and the load/store stage (D side).
// One requester is granted at a time. The memory command is registered and
// issued for exactly one cycle. The response is passed straight through to the
// owner in the done cycle, together with a one-cycle ready pulse.
//
// Parameters
//   WIDTH        data / address width
//   MEM_LATENCY  cycles from the mem_req cycle to mem_rdata valid (>= 1)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_req, i_addr            IF read request (held until i_ready or withdrawn)
//   i_rdata, i_ready         IF read data / completion pulse
//   d_req, d_we, d_addr,
//   d_wdata                  MEM load/store request (held until d_ready or withdrawn)
//   d_rdata, d_ready         MEM load data (0 for stores) / completion pulse
//   mem_req, mem_we,
//   mem_addr, mem_wdata      registered memory command; address and data stay
//                            stable until the next grant
//   mem_rdata                memory read data, MEM_LATENCY cycles after mem_req
//   stall_if, stall_mem      the stage is still waiting for the port
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WIDTH       = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_ready,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             stall_if,
  output logic             stall_mem
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  // Encoding of the last_grant bit.
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic               busy;
  logic               done;
  logic               arb_en;
  logic               grant_i;
  logic               grant_d;

  assign busy   = (state_q != IDLE);
  // Done cycle: the countdown has reached zero, so mem_rdata is valid now.
  assign done   = busy && (cnt_q == '0);
  // The next owner is chosen in the done cycle, so back-to-back transactions
  // need no idle cycle between them.
  assign arb_en = (state_q == IDLE) || done;

  // On a tie, the side that did not win last time is granted. last_grant
  // resets to I, so the first tie after reset goes to D.
  assign grant_d = arb_en && d_req && (!i_req || (last_grant_q == GNT_I));
  assign grant_i = arb_en && i_req && (!d_req || (last_grant_q == GNT_D));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    if (grant_d) begin
      state_d      = BUSY_D;
      cnt_d        = CNT_W'(MEM_LATENCY);
      last_grant_d = GNT_D;
      mem_req_d    = 1'b1;
      mem_we_d     = d_we;
      mem_addr_d   = d_addr;
      mem_wdata_d  = d_wdata;
    end else if (grant_i) begin
      state_d      = BUSY_I;
      cnt_d        = CNT_W'(MEM_LATENCY);
      last_grant_d = GNT_I;
      mem_req_d    = 1'b1;
      mem_we_d     = 1'b0;
      mem_addr_d   = i_addr;
      mem_wdata_d  = '0;
    end else if (done) begin
      state_d      = IDLE;
    end else if (busy) begin
      cnt_d        = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= GNT_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // A requester that withdrew while its access was in flight gets neither a
  // ready pulse nor data; the memory access itself still completes.
  assign i_ready   = i_req && done && (state_q == BUSY_I);
  assign d_ready   = d_req && done && (state_q == BUSY_D);

  assign i_rdata   = i_ready ? mem_rdata : '0;
  assign d_rdata   = (d_ready && !mem_we_q) ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign stall_if  = i_req && !i_ready;
  assign stall_mem = d_req && !d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int W = 32;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, d_req, d_we;
  logic [W-1:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic         i_ready, d_ready, mem_req, mem_we, stall_if, stall_mem;

  mem_port_arbiter #(.WIDTH(W), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory content seen by reads: any fixed scrambling of the address.
  function automatic logic [W-1:0] memval(input logic [W-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  typedef struct { int cyc; logic we; logic [W-1:0] addr; logic [W-1:0] wdata; } cmd_t;
  typedef struct { int cyc; logic [W-1:0] data; } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_i[$];
  rsp_t exp_d[$];
  rsp_t mem_rsp[$];

  // ---------------- memory model: answers each command L cycles later -----
  always @(negedge clk) begin
    if (mem_req === 1'b1) mem_rsp.push_back('{cyc + L, memval(mem_addr)});
  end

  always @(posedge clk) begin
    #1;
    while (mem_rsp.size() > 0 && mem_rsp[0].cyc < cyc) void'(mem_rsp.pop_front());
    if (mem_rsp.size() > 0 && mem_rsp[0].cyc == cyc) begin
      mem_rdata = mem_rsp[0].data;
      void'(mem_rsp.pop_front());
    end else begin
      mem_rdata = $urandom;
    end
  end

  // ---------------- transaction-level reference model ---------------------
  // The port is either free or owned until an absolute done cycle.
  bit           m_busy  = 0;
  int           m_done  = 0;
  bit           m_owner = 0;  // 0 = I, 1 = D
  bit           m_last  = 0;  // owner of the most recent grant
  logic         m_we;
  logic [W-1:0] m_addr;

  always @(posedge clk) begin
    int  t;
    bit  fin, gi, gd;
    #2;
    t   = cyc;
    fin = m_busy && (t == m_done);
    if (fin) begin
      if (!m_owner && i_req) exp_i.push_back('{t, memval(m_addr)});
      if (m_owner && d_req)  exp_d.push_back('{t, m_we ? '0 : memval(m_addr)});
    end
    if (!m_busy || fin) begin
      gi = i_req;
      gd = d_req;
      if (gi && gd) begin
        gi = m_last;
        gd = !m_last;
      end
      if (gi || gd) begin
        m_busy  = 1;
        m_owner = gd;
        m_last  = gd;
        m_done  = t + 1 + L;
        m_we    = gd ? d_we : 1'b0;
        m_addr  = gd ? d_addr : i_addr;
        exp_cmd.push_back('{t + 1, m_we, m_addr, gd ? d_wdata : '0});
      end else begin
        m_busy = 0;
      end
    end
    if (rst) begin
      m_busy = 0;
      m_last = 0;
      while (exp_cmd.size() > 0 && exp_cmd[$].cyc > t) void'(exp_cmd.pop_back());
    end
  end

  // ---------------- monitor / scoreboard ----------------------------------
  logic         held_we    = 1'b0;
  logic [W-1:0] held_addr  = '0;
  logic [W-1:0] held_wdata = '0;
  logic         i_ready_prev = 1'b0;
  logic         d_ready_prev = 1'b0;

  always @(negedge clk) begin
    bit en_c, en_i, en_d;
    while (exp_cmd.size() > 0 && exp_cmd[0].cyc < cyc) begin
      chk(0, "missed_mem_req", '0, exp_cmd[0].addr);
      void'(exp_cmd.pop_front());
    end
    while (exp_i.size() > 0 && exp_i[0].cyc < cyc) void'(exp_i.pop_front());
    while (exp_d.size() > 0 && exp_d[0].cyc < cyc) void'(exp_d.pop_front());

    en_c = exp_cmd.size() > 0 && exp_cmd[0].cyc == cyc;
    en_i = exp_i.size() > 0 && exp_i[0].cyc == cyc;
    en_d = exp_d.size() > 0 && exp_d[0].cyc == cyc;

    chk(mem_req === en_c, "mem_req", W'(mem_req), W'(en_c));
    if (en_c) begin
      chk(mem_addr === exp_cmd[0].addr, "mem_addr", mem_addr, exp_cmd[0].addr);
      chk(mem_we === exp_cmd[0].we, "mem_we", W'(mem_we), W'(exp_cmd[0].we));
      if (exp_cmd[0].we)
        chk(mem_wdata === exp_cmd[0].wdata, "mem_wdata", mem_wdata, exp_cmd[0].wdata);
      held_we    = exp_cmd[0].we;
      held_addr  = exp_cmd[0].addr;
      held_wdata = exp_cmd[0].wdata;
      void'(exp_cmd.pop_front());
    end else begin
      chk(mem_addr === held_addr, "mem_addr_hold", mem_addr, held_addr);
      chk(mem_we === held_we, "mem_we_hold", W'(mem_we), W'(held_we));
      if (held_we)
        chk(mem_wdata === held_wdata, "mem_wdata_hold", mem_wdata, held_wdata);
    end

    chk(i_ready === en_i, "i_ready", W'(i_ready), W'(en_i));
    chk(i_rdata === (en_i ? exp_i[0].data : '0), "i_rdata", i_rdata,
        en_i ? exp_i[0].data : '0);
    chk(d_ready === en_d, "d_ready", W'(d_ready), W'(en_d));
    chk(d_rdata === (en_d ? exp_d[0].data : '0), "d_rdata", d_rdata,
        en_d ? exp_d[0].data : '0);
    chk(stall_if === (i_req && !en_i), "stall_if", W'(stall_if), W'(i_req && !en_i));
    chk(stall_mem === (d_req && !en_d), "stall_mem", W'(stall_mem), W'(d_req && !en_d));
    if (en_i) void'(exp_i.pop_front());
    if (en_d) void'(exp_d.pop_front());

    i_ready_prev = i_ready;
    d_ready_prev = d_ready;
    if (rst) begin
      held_we    = 1'b0;
      held_addr  = '0;
      held_wdata = '0;
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Hold each pending request until its ready pulse, then drop it.
  task automatic serve(input int budget);
    int n = 0;
    while ((i_req || d_req) && n < budget) begin
      step();
      if (i_ready_prev) i_req = 1'b0;
      if (d_ready_prev) d_req = 1'b0;
      n++;
    end
    if (i_req || d_req) begin
      chk(0, "serve_timeout", W'(n), W'(budget));
      i_req = 1'b0; d_req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    step(); step();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk(mem_req === 1'b0, "rst_mem_req", W'(mem_req), '0);
    chk(mem_addr === '0, "rst_mem_addr", mem_addr, '0);
    chk(mem_wdata === '0, "rst_mem_wdata", mem_wdata, '0);
    chk(mem_we === 1'b0, "rst_mem_we", W'(mem_we), '0);
    chk({i_ready, d_ready, stall_if, stall_mem} === 4'b0, "rst_outputs",
        W'({i_ready, d_ready, stall_if, stall_mem}), '0);

    // single fetch
    step();
    i_req = 1'b1; i_addr = 32'h40;
    serve(20);
    repeat (6) step();

    // tie after reset goes to D
    do_reset();
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    chk(mem_addr === 32'h100, "tie_first_D", mem_addr, 32'h100);
    serve(30);
    repeat (4) step();

    // fairness: both held continuously
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    repeat (18) step();
    i_req = 1'b0; d_req = 1'b0;
    repeat (6) step();

    // store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    serve(20);
    repeat (4) step();

    // fetch withdrawn one cycle after grant, pending load granted in done cycle
    i_req = 1'b1; i_addr = 32'h300;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    step();
    i_req = 1'b0;
    serve(20);
    repeat (4) step();

    // reset one cycle after mem_req, tie rule restarts with D
    do_reset();
    i_req = 1'b1; i_addr = 32'h700;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk(mem_addr === 32'h800, "post_rst_tie_D", mem_addr, 32'h800);
    serve(30);
    repeat (4) step();

    // randomized traffic
    repeat (3000) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (i_req) begin
        if (i_ready_prev) begin
          i_req  = $urandom_range(0, 1);
          i_addr = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          i_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_req  = 1'b1;
        i_addr = $urandom;
      end
      if (d_req) begin
        if (d_ready_prev || $urandom_range(0, 15) == 0) d_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_we    = $urandom_range(0, 1);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
    end
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (L + 6) step();
    chk(exp_cmd.size() == 0, "cmd_queue_drained", W'(exp_cmd.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
